cpu_lr_stack: RTL and testbench

//   Return-address LIFO, the reader/consumer side of the link register. The

---
 rtl/cpu_lr_stack.sv | 118 +++++++++++
 tb/tb_cpu_lr_stack.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_lr_stack.sv
// ----------------------------------------------------------------------------
// cpu_lr_stack
//   Return-address LIFO on the consumer side of the link register. The control
//   unit pushes the link value on CALL and pops it on RET. A popped address is
//   presented to the PC mux as a registered one-cycle RET_VALID/RET_ADDR pair.
//   Nested calls are supported up to DEPTH = 2**AW levels.
//
// Ports
//   CLK        in   1      system clock, all state updates on rising edge
//   RST        in   1      synchronous reset, active high
//   PUSH       in   1      push request (CALL)
//   POP        in   1      pop request (RET)
//   PUSH_DATA  in   WIDTH  value pushed (normally LR_OUT)
//   TOP_OUT    out  WIDTH  combinational peek at top entry, 0 when EMPTY
//   RET_ADDR   out  WIDTH  registered popped address
//   RET_VALID  out  1      one-cycle pulse: RET_ADDR updated by a pop
//   EMPTY      out  1      no entries held
//   FULL       out  1      DEPTH entries held
//   OVF        out  1      sticky: push attempted while FULL
//   UNF        out  1      sticky: pop attempted while EMPTY
// ----------------------------------------------------------------------------
module cpu_lr_stack #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PUSH,
  input  logic             POP,
  input  logic [WIDTH-1:0] PUSH_DATA,
  output logic [WIDTH-1:0] TOP_OUT,
  output logic [WIDTH-1:0] RET_ADDR,
  output logic             RET_VALID,
  output logic             EMPTY,
  output logic             FULL,
  output logic             OVF,
  output logic             UNF
);

  localparam int DEPTH = 2 ** AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      cnt;        // 0..DEPTH, one bit wider than the pointer
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] top_val;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;

  // When cnt == DEPTH the low bits wrap to 0, so subtracting one still lands
  // on DEPTH-1; only the EMPTY case yields a meaningless index, and it is
  // masked below.
  assign top_idx = cnt[AW-1:0] - 1'b1;
  assign top_val = mem[top_idx];

  assign EMPTY   = (cnt == '0);
  assign FULL    = cnt[AW];
  assign TOP_OUT = EMPTY ? '0 : top_val;

  // A plain push writes the next free slot; a swap overwrites the top entry.
  // A bypass on an empty stack and every overflowing push write nothing.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    wr_en  = 1'b0;
    wr_idx = cnt[AW-1:0];
    if (!RST && PUSH) begin
      if (POP && !EMPTY) begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else if (!POP && !FULL) begin
        wr_en  = 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset; entries above cnt are never
  // observed, so clearing them would only cost logic and block RAM mapping.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_idx] <= PUSH_DATA;
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values regardless of statement order.
    if (RST) begin
      cnt       <= '0;
      RET_ADDR  <= '0;
      RET_VALID <= 1'b0;
      OVF       <= 1'b0;
      UNF       <= 1'b0;
    end else begin
      RET_VALID <= 1'b0;
      case ({PUSH, POP})
        2'b10: begin
          if (FULL) OVF <= 1'b1;
          else      cnt <= cnt + 1'b1;
        end
        2'b01: begin
          if (EMPTY) begin
            UNF <= 1'b1;
          end else begin
            RET_ADDR  <= top_val;
            RET_VALID <= 1'b1;
            cnt       <= cnt - 1'b1;
          end
        end
        2'b11: begin
          // Swap when holding entries, bypass straight through when empty;
          // either way the depth is unchanged and no error flag is raised.
          RET_ADDR  <= EMPTY ? PUSH_DATA : top_val;
          RET_VALID <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_lr_stack.sv
// ----------------------------------------------------------------------------
// tb_cpu_lr_stack
//   Drives cpu_lr_stack with directed scenarios followed by randomized
//   push/pop/reset traffic and compares every output after each edge with a
//   queue-based reference model of the return-address stack.
// ----------------------------------------------------------------------------
module tb_cpu_lr_stack;

  localparam int WIDTH = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 2 ** AW;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             PUSH = 1'b0;
  logic             POP = 1'b0;
  logic [WIDTH-1:0] PUSH_DATA = '0;
  logic [WIDTH-1:0] TOP_OUT;
  logic [WIDTH-1:0] RET_ADDR;
  logic             RET_VALID;
  logic             EMPTY;
  logic             FULL;
  logic             OVF;
  logic             UNF;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [WIDTH-1:0] m_stack[$];
  logic [WIDTH-1:0] m_ret_addr  = '0;
  logic             m_ret_valid = 1'b0;
  logic             m_ovf       = 1'b0;
  logic             m_unf       = 1'b0;

  cpu_lr_stack #(.WIDTH(WIDTH), .AW(AW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .PUSH      (PUSH),
    .POP       (POP),
    .PUSH_DATA (PUSH_DATA),
    .TOP_OUT   (TOP_OUT),
    .RET_ADDR  (RET_ADDR),
    .RET_VALID (RET_VALID),
    .EMPTY     (EMPTY),
    .FULL      (FULL),
    .OVF       (OVF),
    .UNF       (UNF)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Stack semantics straight from the behavioural rules.
  task automatic model_update(input bit rst, input bit push, input bit pop,
                              input logic [WIDTH-1:0] d);
    if (rst) begin
      m_stack.delete();
      m_ret_addr  = '0;
      m_ret_valid = 1'b0;
      m_ovf       = 1'b0;
      m_unf       = 1'b0;
    end else if (push && pop) begin
      if (m_stack.size() == 0) begin
        m_ret_addr = d;
      end else begin
        m_ret_addr = m_stack.pop_back();
        m_stack.push_back(d);
      end
      m_ret_valid = 1'b1;
    end else if (push) begin
      if (m_stack.size() == DEPTH) m_ovf = 1'b1;
      else                         m_stack.push_back(d);
      m_ret_valid = 1'b0;
    end else if (pop) begin
      if (m_stack.size() == 0) begin
        m_unf       = 1'b1;
        m_ret_valid = 1'b0;
      end else begin
        m_ret_addr  = m_stack.pop_back();
        m_ret_valid = 1'b1;
      end
    end else begin
      m_ret_valid = 1'b0;
    end
  endtask

  task automatic compare_all(input string tag);
    logic [WIDTH-1:0] exp_top;
    int               n;
    n       = m_stack.size();
    exp_top = (n == 0) ? '0 : m_stack[n-1];
    check({tag, ".TOP_OUT"},   32'(TOP_OUT),   32'(exp_top));
    check({tag, ".EMPTY"},     32'(EMPTY),     32'(n == 0));
    check({tag, ".FULL"},      32'(FULL),      32'(n == DEPTH));
    check({tag, ".RET_VALID"}, 32'(RET_VALID), 32'(m_ret_valid));
    check({tag, ".RET_ADDR"},  32'(RET_ADDR),  32'(m_ret_addr));
    check({tag, ".OVF"},       32'(OVF),       32'(m_ovf));
    check({tag, ".UNF"},       32'(UNF),       32'(m_unf));
  endtask

  // One clock: drive on the falling edge, sample 1 ns after the rising edge.
  task automatic step(input string tag, input bit rst, input bit push,
                      input bit pop, input logic [WIDTH-1:0] d);
    @(negedge CLK);
    RST       = rst;
    PUSH      = push;
    POP       = pop;
    PUSH_DATA = d;
    @(posedge CLK);
    model_update(rst, push, pop, d);
    #1;
    compare_all(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] vals[3];
    int               bias;

    // 1. Reset state.
    step("reset", 1'b1, 1'b0, 1'b0, 8'h00);
    check("reset.EMPTY_const", 32'(EMPTY), 32'd1);
    check("reset.RET_ADDR_const", 32'(RET_ADDR), 32'd0);

    // 2. Three pushes then three back-to-back pops.
    vals[0] = 8'hA7; vals[1] = 8'h13; vals[2] = 8'h5C;
    for (int i = 0; i < 3; i++) step("t2.push", 1'b0, 1'b1, 1'b0, vals[i]);
    check("t2.top_before_pop", 32'(TOP_OUT), 32'h5C);
    for (int i = 2; i >= 0; i--) begin
      step("t2.pop", 1'b0, 1'b0, 1'b1, 8'h00);
      check("t2.ret_seq", 32'(RET_ADDR), 32'(vals[i]));
      check("t2.ret_pulse", 32'(RET_VALID), 32'd1);
    end
    step("t2.idle", 1'b0, 1'b0, 1'b0, 8'h00);

    // 3. Fill to DEPTH, overflow, drain.
    for (int i = 0; i < DEPTH; i++)
      step("t3.fill", 1'b0, 1'b1, 1'b0, 8'(i));
    check("t3.full", 32'(FULL), 32'd1);
    step("t3.ovf", 1'b0, 1'b1, 1'b0, 8'hFF);
    check("t3.ovf_flag", 32'(OVF), 32'd1);
    check("t3.top_after_ovf", 32'(TOP_OUT), 32'h07);
    for (int i = DEPTH - 1; i >= 0; i--)
      step("t3.drain", 1'b0, 1'b0, 1'b1, 8'h00);

    // 4. Underflow, then a push keeps UNF sticky.
    step("t4.unf", 1'b0, 1'b0, 1'b1, 8'h00);
    check("t4.unf_flag", 32'(UNF), 32'd1);
    step("t4.push42", 1'b0, 1'b1, 1'b0, 8'h42);
    check("t4.top42", 32'(TOP_OUT), 32'h42);
    step("t4.pop42", 1'b0, 1'b0, 1'b1, 8'h00);

    // 5. Swap with entries held, bypass when empty.
    step("t5.push11", 1'b0, 1'b1, 1'b0, 8'h11);
    step("t5.push22", 1'b0, 1'b1, 1'b0, 8'h22);
    step("t5.swap", 1'b0, 1'b1, 1'b1, 8'h33);
    check("t5.swap_ret", 32'(RET_ADDR), 32'h22);
    check("t5.swap_top", 32'(TOP_OUT), 32'h33);
    step("t5.pop", 1'b0, 1'b0, 1'b1, 8'h00);
    step("t5.pop", 1'b0, 1'b0, 1'b1, 8'h00);
    step("t5.bypass", 1'b0, 1'b1, 1'b1, 8'h44);
    check("t5.bypass_ret", 32'(RET_ADDR), 32'h44);
    check("t5.bypass_empty", 32'(EMPTY), 32'd1);

    // 6. Reset during a pop discards the pop.
    for (int i = 0; i < 3; i++)
      step("t6.push", 1'b0, 1'b1, 1'b0, 8'($urandom));
    step("t6.rst_pop", 1'b1, 1'b0, 1'b1, 8'h00);
    check("t6.ret_valid", 32'(RET_VALID), 32'd0);
    check("t6.ret_addr", 32'(RET_ADDR), 32'd0);

    // Randomized traffic; the push/pop bias drifts so the stack regularly
    // reaches both FULL and EMPTY.
    bias = 50;
    for (int i = 0; i < 3000; i++) begin
      bit rst, push, pop;
      if ((i % 40) == 0) bias = 15 + 70 * $urandom_range(0, 1);
      rst  = ($urandom_range(0, 199) == 0);
      push = ($urandom_range(0, 99) < bias);
      pop  = ($urandom_range(0, 99) < (100 - bias));
      step("rand", rst, push, pop, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
